// File: rtl/seg_scan_if.sv
// Avalon-MM slave bus bundle for the segment scan controller.
// The master side drives address/strobes; the slave returns zero-latency readdata.
interface seg_scan_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/seg_scan_controller.sv
// Multiplexed 7-segment scan controller: per-digit registers, round-robin scan with
// programmable dwell, blanking gap between digits and optional hex decode.
module seg_scan_controller #(
    parameter int NUM_DIGITS       = 4,
    parameter int DIV_WIDTH        = 16,
    parameter int DEFAULT_DIV      = 50000,
    parameter int BLANK_CYCLES     = 64,
    parameter int SEG_ACTIVE_LOW   = 1,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    seg_scan_if.slave             bus,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_pulse
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHOW  = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    localparam int CNT_W = (DIV_WIDTH > $clog2(BLANK_CYCLES + 1)) ? DIV_WIDTH : $clog2(BLANK_CYCLES + 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;

    function automatic logic [6:0] f_hex7(input logic [3:0] v);
        case (v)
            4'h0: f_hex7 = 7'h3F;  4'h1: f_hex7 = 7'h06;  4'h2: f_hex7 = 7'h5B;  4'h3: f_hex7 = 7'h4F;
            4'h4: f_hex7 = 7'h66;  4'h5: f_hex7 = 7'h6D;  4'h6: f_hex7 = 7'h7D;  4'h7: f_hex7 = 7'h07;
            4'h8: f_hex7 = 7'h7F;  4'h9: f_hex7 = 7'h6F;  4'hA: f_hex7 = 7'h77;  4'hB: f_hex7 = 7'h7C;
            4'hC: f_hex7 = 7'h39;  4'hD: f_hex7 = 7'h5E;  4'hE: f_hex7 = 7'h79;  default: f_hex7 = 7'h71;
        endcase
    endfunction

    logic [6:0]            r_digit [NUM_DIGITS];
    logic                  r_en;
    logic                  r_raw;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [1:0]            r_state;
    logic [2:0]            r_idx;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_wr;
    logic [CNT_W-1:0]      w_dwell_load;
    logic [1:0]            w_state_nxt;
    logic [2:0]            w_idx_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_wrap;
    logic [6:0]            w_sel_digit;
    logic [6:0]            w_pat;
    logic [NUM_DIGITS-1:0] w_den;
    logic                  w_unused_wdata;

    assign w_wr           = bus.chipselect & ~bus.write_n;
    assign w_unused_wdata = ^bus.writedata;
    // A stored divisor of 0 behaves as 1, i.e. a load value of 0.
    assign w_dwell_load   = (r_div == '0) ? '0 : CNT_W'(r_div - DIV_WIDTH'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= '0;
            r_en  <= 1'b0;
            r_raw <= 1'b0;
            r_div <= DIV_WIDTH'(DEFAULT_DIV);
        end else if (w_wr) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                if (bus.address == 3'(i)) r_digit[i] <= bus.writedata[6:0];
            if (bus.address == 3'd4) begin
                r_en  <= bus.writedata[0];
                r_raw <= bus.writedata[1];
            end
            if (bus.address == 3'd5) r_div <= bus.writedata[DIV_WIDTH-1:0];
        end
    end

    always_comb begin
        bus.readdata = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bus.address == 3'(i)) bus.readdata = {25'd0, r_digit[i]};
        case (bus.address)
            3'd4:    bus.readdata = {30'd0, r_raw, r_en};
            3'd5:    bus.readdata = 32'(r_div);
            3'd6:    bus.readdata = {22'd0, r_state, 5'd0, r_idx};
            default: ;
        endcase
    end

    // Clearing EN wins over every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_wrap      = 1'b0;
        if (!r_en) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 3'd0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SHOW;
                    w_idx_nxt   = 3'd0;
                    w_cnt_nxt   = w_dwell_load;
                end
                ST_SHOW: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = BLANK_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ST_BLANK: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_SHOW;
                        w_cnt_nxt   = w_dwell_load;
                        if (r_idx == LAST_IDX) begin
                            w_idx_nxt = 3'd0;
                            w_wrap    = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + 3'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = 3'd0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Pins are registered from the next-state view so they line up with r_state.
    always_comb begin
        w_sel_digit = '0;
        w_den       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == 3'(i)) w_sel_digit = r_digit[i];
            w_den[i] = (w_state_nxt == ST_SHOW) && (w_idx_nxt == 3'(i));
        end
        w_pat = r_raw ? w_sel_digit : f_hex7(w_sel_digit[3:0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_cnt       <= '0;
            seg_out     <= SEG_OFF;
            digit_en    <= DIG_OFF;
            frame_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            seg_out     <= (w_state_nxt != ST_SHOW) ? SEG_OFF :
                           (SEG_ACTIVE_LOW != 0) ? ~w_pat : w_pat;
            digit_en    <= (DIGIT_ACTIVE_LOW != 0) ? ~w_den : w_den;
            frame_pulse <= w_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: expected digit runs are queued as stimulus
// is applied and compared against observed runs of (digit_en, seg_out) on the pins.
module tb_seg_scan_controller;

    localparam int ND    = 4;
    localparam int DW    = 16;
    localparam int DDIV  = 50000;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] seg_out;
    logic [3:0] digit_en;
    logic       frame_pulse;

    seg_scan_if bus_if();

    seg_scan_controller #(
        .NUM_DIGITS(ND), .DIV_WIDTH(DW), .DEFAULT_DIV(DDIV), .BLANK_CYCLES(BLANK),
        .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_if),
        .seg_out(seg_out), .digit_en(digit_en), .frame_pulse(frame_pulse)
    );

    always #5 clk = ~clk;

    logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] en;
        logic [6:0] seg;
        int         len;
    } exp_t;
    exp_t sb[$];

    function automatic logic [3:0] en_of(input int d);
        logic [3:0] one;
        one = 4'b0001 << d;
        return ~one;
    endfunction

    task automatic push_exp(input logic [3:0] en, input logic [6:0] seg, input int len);
        exp_t e;
        e.en = en; e.seg = seg; e.len = len;
        sb.push_back(e);
    endtask

    // Run-length monitor
    logic       mon_on = 1'b0;
    logic [3:0] run_en;
    logic [6:0] run_seg;
    int         run_len = 0;
    int         seen_show = 0;
    int         cyc = 0;
    int         last_fp = -1;
    int         fp_cnt = 0;
    int         exp_fp = 0;

    task automatic close_run();
        exp_t e;
        if (run_en != 4'hF) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_val("run_en",  32'(run_en),  32'(e.en));
                check_val("run_seg", 32'(run_seg), 32'(e.seg));
                check_val("run_len", run_len, e.len);
                seen_show = 1;
            end
        end else if (seen_show != 0 && sb.size() > 0) begin
            check_val("blank_len", run_len, BLANK);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (mon_on) begin
            if (run_len > 0 && digit_en == run_en && seg_out == run_seg) begin
                run_len++;
            end else begin
                if (run_len > 0) close_run();
                run_en  = digit_en;
                run_seg = seg_out;
                run_len = 1;
            end
            if (frame_pulse) begin
                check_val("fp_digit0", 32'(digit_en), 32'hE);
                if (last_fp >= 0 && exp_fp > 0) check_val("fp_period", cyc - last_fp, exp_fp);
                last_fp = cyc;
                fp_cnt++;
            end
        end
    end

    task automatic mon_start(input int period);
        run_len   = 0;
        seen_show = 0;
        last_fp   = -1;
        fp_cnt    = 0;
        exp_fp    = period;
        mon_on    = 1'b1;
    endtask

    task automatic wait_sb(input int budget);
        int b = 0;
        while (sb.size() > 0 && b < budget) begin
            @(posedge clk);
            b++;
        end
        check_val("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus_if.address = a; bus_if.writedata = d; bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
        @(posedge clk); #1;
        bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus_if.address = a; bus_if.chipselect = 1'b1; bus_if.write_n = 1'b1;
        #1 d = bus_if.readdata;
        bus_if.chipselect = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [2:0]  idx [9];
        logic [6:0]  raw_v [4];
        int          found;
        int          len;
        int          guard;

        bus_if.address = '0; bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; bus_if.writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_seg", 32'(seg_out), 32'h7F);
        check_val("rst_en",  32'(digit_en), 32'hF);
        check_val("rst_fp",  32'(frame_pulse), 32'h0);
        reset_n = 1'b1;

        // Reset asserted in the middle of a SHOW dwell
        bus_write(3'd0, 32'h5);
        bus_write(3'd5, 32'd10);
        bus_write(3'd4, 32'h1);
        repeat (6) @(posedge clk);
        #1;
        check_val("pre_rst_show", 32'(digit_en), 32'hE);
        #2 reset_n = 1'b0;
        #1;
        check_val("async_rst_seg", 32'(seg_out), 32'h7F);
        check_val("async_rst_en",  32'(digit_en), 32'hF);
        @(posedge clk); #1 reset_n = 1'b1;
        bus_read(3'd4, rd); check_val("rst_ctrl", rd, 32'h0);
        bus_read(3'd5, rd); check_val("rst_div", rd, DDIV);
        for (int i = 0; i < ND; i++) begin
            bus_read(3'(i), rd); check_val("rst_digit", rd, 32'h0);
        end
        bus_read(3'd6, rd); check_val("rst_status", rd, 32'h0);
        bus_read(3'd7, rd); check_val("unmapped_rd", rd, 32'h0);

        // Hex-decoded scan over three frames
        for (int i = 0; i < ND; i++) bus_write(3'(i), 32'(i + 1));
        bus_write(3'd5, 32'd10);
        mon_start(4 * (10 + BLANK));
        for (int f = 0; f < 3; f++)
            for (int d = 0; d < ND; d++) push_exp(en_of(d), ~HEX[d + 1], 10);
        bus_write(3'd4, 32'h1);
        wait_sb(400);
        check_val("fp_count", fp_cnt, 2);

        // RAW mode
        bus_write(3'd4, 32'h0);
        mon_on = 1'b0;
        bus_write(3'd2, 32'h49);
        raw_v[0] = 7'h01; raw_v[1] = 7'h02; raw_v[2] = 7'h49; raw_v[3] = 7'h04;
        mon_start(4 * (10 + BLANK));
        for (int d = 0; d < ND; d++) push_exp(en_of(d), ~raw_v[d], 10);
        bus_write(3'd4, 32'h3);
        wait_sb(200);
        bus_read(3'd4, rd); check_val("raw_ctrl", rd, 32'h3);

        // Divisor zero behaves as one
        bus_write(3'd4, 32'h0);
        mon_on = 1'b0;
        bus_write(3'd5, 32'h0);
        bus_read(3'd5, rd); check_val("div0_rd", rd, 32'h0);
        mon_start(4 * (1 + BLANK));
        push_exp(en_of(0), ~HEX[1], 1);
        push_exp(en_of(1), ~HEX[2], 1);
        push_exp(en_of(2), ~HEX[9], 1);
        push_exp(en_of(3), ~HEX[4], 1);
        bus_write(3'd4, 32'h1);
        wait_sb(100);
        @(posedge clk); #1;
        bus_if.address = 3'd6; bus_if.chipselect = 1'b1; bus_if.write_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            idx[i] = bus_if.readdata[2:0];
        end
        bus_if.chipselect = 1'b0;
        for (int i = 0; i < 6; i++)
            check_val("div0_idx_step", 32'(idx[i + 3]), (int'(idx[i]) + 1) % ND);

        // Disable mid-dwell of digit 2, then re-enable
        mon_on = 1'b0;
        bus_write(3'd4, 32'h0);
        bus_write(3'd5, 32'd10);
        bus_write(3'd4, 32'h1);
        found = 0;
        for (int b = 0; b < 200 && found == 0; b++) begin
            bus_read(3'd6, rd);
            if (rd[9:8] == 2'd1 && rd[2:0] == 3'd2) found = 1;
        end
        check_val("dis_found_show2", found, 1);
        bus_write(3'd4, 32'h0);
        bus_read(3'd6, rd);
        check_val("dis_status", rd, 32'h0);
        check_val("dis_seg", 32'(seg_out), 32'h7F);
        check_val("dis_en",  32'(digit_en), 32'hF);
        check_val("dis_fp",  32'(frame_pulse), 32'h0);
        mon_start(0);
        push_exp(en_of(0), ~HEX[1], 10);
        bus_write(3'd4, 32'h1);
        wait_sb(100);
        mon_on = 1'b0;

        // Live DIGIT1 update during its own SHOW
        found = 0;
        for (int b = 0; b < 100 && found == 0; b++) begin
            @(negedge clk);
            if (digit_en == 4'hD) found = 1;
        end
        check_val("live_found", found, 1);
        len = 1;
        @(posedge clk); #1;
        bus_if.address = 3'd1; bus_if.writedata = 32'h8; bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
        @(negedge clk);
        len++;
        check_val("live_en", 32'(digit_en), 32'hD);
        @(posedge clk); #1;
        bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
        @(negedge clk);
        len++;
        @(negedge clk);
        len++;
        check_val("live_seg", 32'(seg_out), 32'h00);
        guard = 0;
        @(negedge clk);
        while (digit_en == 4'hD && guard < 50) begin
            len++;
            guard++;
            @(negedge clk);
        end
        check_val("live_show_len", len, 10);
        bus_read(3'd1, rd); check_val("live_digit1_rd", rd, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
